// File: rtl/gate_tester_pkg.sv
// Shared definitions for the two-input gate tester: FSM encoding, common
// truth tables and a saturating counter helper.
package gate_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Truth tables are indexed by {A,B}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gate_tester_settle_counter.sv
// Loadable down-counter timing one vector window; expire marks the compare
// edge and the counter reloads itself so consecutive windows run back to back.
module settle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign expire = en && !load && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? load_val : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gate_tester.sv
// Sweeps {A,B} through all four vectors PASSES times, compares the gate output
// Y against TRUTH at the end of each settle window and reports the outcome.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter logic [3:0] TRUTH  = TT_AND,
    parameter int         SETTLE = 2,
    parameter int         PASSES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [7:0] err_count
);

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE);
    localparam logic [5:0] LAST_PASS = 6'(PASSES - 1);

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  fail_vec_q, fail_vec_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [5:0]  pass_cnt_q, pass_cnt_d;

    logic accept;
    logic run_en;
    logic expire;
    logic mismatch;
    logic last_cmp;

    assign accept   = (state_q == ST_IDLE) && start;
    assign run_en   = (state_q == ST_RUN);
    assign mismatch = (Y != TRUTH[vec_q]);
    assign last_cmp = expire && (vec_q == 2'd3) && (pass_cnt_q == LAST_PASS);

    settle_counter #(
        .WIDTH(8)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .en       (run_en),
        .load_val (SETTLE_LD),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_cmp) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        pass_cnt_d  = pass_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    vec_d       = 2'd0;
                    fail_vec_d  = 4'd0;
                    err_count_d = 8'd0;
                    pass_d      = 1'b0;
                    pass_cnt_d  = 6'd0;
                end
            end
            ST_RUN: begin
                if (expire) begin
                    if (mismatch) begin
                        fail_vec_d[vec_q] = 1'b1;
                        err_count_d       = sat_inc8(err_count_q);
                    end
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 6'd1;
                    // Final compare still counts toward pass, hence fail_vec_d
                    if (last_cmp) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        vec_d  = 2'd0;
                        pass_d = (fail_vec_d == 4'd0);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= 4'd0;
            err_count_q <= 8'd0;
            pass_cnt_q  <= 6'd0;
        end else begin
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    assign A         = vec_q[1];
    assign B         = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_tester.sv
// Randomized bench for gate_tester: three configurations driven by a
// table-described gate, checked against an arithmetic model of a run.
module tb_gate_tester;
    import gate_tester_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start, a, b, y, busy, done, pass_o;
    logic [3:0] fvec [3];
    logic [7:0] errc [3];
    logic [3:0] ymap [3];

    int         s_tab [3] = '{2, 2, 0};
    int         p_tab [3] = '{1, 3, 1};
    logic [3:0] t_tab [3] = '{TT_AND, TT_AND, TT_XOR};

    int errors = 0;
    int checks = 0;

    // The gate under test is modelled as a 4-entry table indexed by {A,B}
    assign y[0] = ymap[0][{a[0], b[0]}];
    assign y[1] = ymap[1][{a[1], b[1]}];
    assign y[2] = ymap[2][{a[2], b[2]}];

    gate_tester u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .A(a[0]), .B(b[0]), .Y(y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass_o[0]), .fail_vec(fvec[0]), .err_count(errc[0])
    );

    gate_tester #(.TRUTH(TT_AND), .SETTLE(2), .PASSES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .A(a[1]), .B(b[1]), .Y(y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass_o[1]), .fail_vec(fvec[1]), .err_count(errc[1])
    );

    gate_tester #(.TRUTH(TT_XOR), .SETTLE(0), .PASSES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .A(a[2]), .B(b[2]), .Y(y[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass_o[2]), .fail_vec(fvec[2]), .err_count(errc[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_fail(input logic [3:0] gate, input logic [3:0] truth);
        logic [3:0] f;
        for (int v = 0; v < 4; v++) f[v] = (gate[v] != truth[v]);
        return f;
    endfunction

    function automatic int model_errs(input logic [3:0] f, input int passes);
        int e;
        e = passes * $countones(f);
        return (e > 255) ? 255 : e;
    endfunction

    // One complete run on DUT d; optionally pokes start mid-run.
    task automatic run_once(input int d, input bit poke);
        int         n, c;
        bit         seq_ok;
        logic [3:0] ef;
        n  = 4 * p_tab[d] * (s_tab[d] + 1);
        ef = model_fail(ymap[d], t_tab[d]);
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        check_eq($sformatf("d%0d_busy_rise", d), 32'(busy[d]), 32'd1);
        c = 0;
        seq_ok = 1'b1;
        while (busy[d] && c < n + 50) begin
            if ({a[d], b[d]} != 2'((c / (s_tab[d] + 1)) % 4)) seq_ok = 1'b0;
            if (done[d]) seq_ok = 1'b0;
            start[d] = (poke && c == 3);
            c++;
            @(negedge clk);
        end
        start[d] = 1'b0;
        check_eq($sformatf("d%0d_vec_seq", d), 32'(seq_ok), 32'd1);
        check_eq($sformatf("d%0d_busy_len", d), c, n);
        check_eq($sformatf("d%0d_done", d), 32'(done[d]), 32'd1);
        check_eq($sformatf("d%0d_pass", d), 32'(pass_o[d]), 32'(ef == 4'd0));
        check_eq($sformatf("d%0d_fail_vec", d), 32'(fvec[d]), 32'(ef));
        check_eq($sformatf("d%0d_err_count", d), 32'(errc[d]), model_errs(ef, p_tab[d]));
        check_eq($sformatf("d%0d_ab_end", d), 32'({a[d], b[d]}), 32'd0);
        $display("run dut=%0d gate=%b truth=%b poke=%0d cycles=%0d pass=%0d fail_vec=%b err=%0d",
                 d, ymap[d], t_tab[d], poke, c, pass_o[d], fvec[d], errc[d]);
        @(negedge clk);
        check_eq($sformatf("d%0d_done_fall", d), 32'(done[d]), 32'd0);
        check_eq($sformatf("d%0d_pass_hold", d), 32'(pass_o[d]), 32'(ef == 4'd0));
    endtask

    initial begin
        int t, last, pulses, seen;
        rst_n = 1'b0;
        start = '0;
        ymap[0] = TT_AND; ymap[1] = TT_AND; ymap[2] = TT_XOR;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst%0d_outs", d),
                     {15'd0, a[d], b[d], busy[d], done[d], pass_o[d], fvec[d], errc[d]}, 32'd0);
        end

        // Directed: correct gates, stuck-at gates
        run_once(0, 1'b0);
        ymap[0] = 4'b0000; run_once(0, 1'b0);
        ymap[1] = 4'b1111; run_once(1, 1'b0);
        run_once(2, 1'b0);
        ymap[0] = TT_AND; run_once(0, 1'b1);

        // Reset mid-run: vector 00 already mismatched before the reset edge
        ymap[0] = 4'b1111;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_outs",
                 {15'd0, a[0], b[0], busy[0], done[0], pass_o[0], fvec[0], errc[0]}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0] || busy[0]) seen++;
        end
        check_eq("mid_rst_quiet", seen, 0);
        $display("reset mid-run dut=0 quiet_cycles_with_activity=%0d", seen);
        ymap[0] = TT_AND; run_once(0, 1'b0);

        // Start held high: done period is N+2
        start[0] = 1'b1;
        t = 0; last = -1; pulses = 0;
        while (pulses < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (done[0]) begin
                if (last >= 0) check_eq("hold_period", t - last, 4 * p_tab[0] * (s_tab[0] + 1) + 2);
                $display("held start done pulse at cycle %0d", t);
                last = t;
                pulses++;
            end
        end
        start[0] = 1'b0;
        check_eq("hold_pulses", pulses, 3);
        repeat (20) @(negedge clk);

        // Random gates against every configuration
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 3; d++) begin
                ymap[d] = 4'($urandom_range(0, 15));
                run_once(d, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
